board_input_conditioner: RTL
============================

// Module: board_input_conditioner
//
// PURPOSE
//   Conditions raw FPGA board inputs before they reach the system FPGA wrapper.
//   - Synchronises the slide switches.
//   - Debounces the push buttons and emits per-button press/release pulses.
//   - Generates a stretched system reset from power-on reset or a held reset button.
//   Sits between the board pins (BTN/SW) and the wrapper's syif.addr / nRST mapping.
//
// PARAMETERS
//   NBTN            4          number of push buttons
//   NSW             16         number of slide switches
//   SYNC_STAGES     2          flip-flops per synchroniser chain (>=2)
//   DEBOUNCE_CYCLES 1000000    stable cycles required to accept a button change (10 ms @ 100 MHz)
//   RST_HOLD        16         cycles sys_nRST stays low after a reset source ends (>=1)
//   RST_BTN         3          index of the button that acts as system reset
//
// PORTS
//   CLK          in   1      system clock (CLK_100MHZ on board)
//   nRST         in   1      asynchronous active-low reset (power-on / auto reset)
//   btn_raw      in   NBTN   raw push-button pins, active-high, asynchronous
//   sw_raw       in   NSW    raw slide-switch pins, asynchronous
//   btn_level    out  NBTN   debounced button state
//   btn_press    out  NBTN   1-cycle pulse on debounced 0->1
//   btn_release  out  NBTN   1-cycle pulse on debounced 1->0
//   sw_sync      out  NSW    synchronised switch value
//   sw_changed   out  1      1-cycle pulse when sw_sync differs from its previous value
//   sys_nRST     out  1      stretched active-low system reset, registered
//
// BEHAVIOUR
//   Reset:
//   - One clock; nRST is asynchronous, active-low.
//   - nRST low clears all registers immediately. btn_level, btn_press, btn_release,
//     sw_sync and sw_changed go to 0; sys_nRST goes to 0.
//   - nRST asserted mid-operation aborts any debounce count and any reset stretch.
//
//   Synchronisers:
//   - Each btn_raw/sw_raw bit passes through SYNC_STAGES flops.
//   - A change appears at the chain output SYNC_STAGES edges later.
//   - No reset-release glitch: flops clear to 0.
//
//   Debounce (independent per button):
//   - Counter width $clog2(DEBOUNCE_CYCLES).
//   - Synced value == btn_level: counter clears to 0.
//   - Synced value != btn_level: counter increments.
//   - On the edge where counter == DEBOUNCE_CYCLES-1 with mismatch still present:
//     btn_level takes the synced value and counter clears.
//   - Any bounce back to the current level clears the counter. No partial credit; never wraps.
//   - Total latency from a clean raw change to btn_level: SYNC_STAGES+DEBOUNCE_CYCLES edges.
//   - btn_press/btn_release are registered in the same edge btn_level updates; high exactly one cycle.
//
//   Switches:
//   - Not debounced; sw_sync = synchroniser output.
//   - sw_changed = registered (sw_sync != sw_sync_prev), high one cycle per change event.
//   - sw_sync_prev resets to 0; a switch high at reset release therefore yields one sw_changed pulse.
//
//   Reset FSM, states {HOLD, RUN, BTN}:
//   - nRST low forces HOLD and loads the hold counter with RST_HOLD-1.
//   - HOLD: sys_nRST=0; counter decrements each cycle; at 0 go to RUN.
//   - HOLD: btn_level[RST_BTN]==1 goes to BTN; this takes priority over the count.
//   - RUN: sys_nRST=1; btn_level[RST_BTN] rising goes to BTN.
//   - BTN: sys_nRST=0 while btn_level[RST_BTN]==1; when it falls, go to HOLD and reload the counter.
//   - sys_nRST is a registered function of next state; glitch-free.
//   - sys_nRST stays low RST_HOLD cycles after nRST deasserts.
//   - sys_nRST stays low for the whole press plus RST_HOLD cycles after debounced release.
//
// TESTING  (bench params: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RST_HOLD=3)
//   1. Hold nRST low 5 cycles, release at edge 0 -> all outputs 0 during reset;
//      sys_nRST=0 through edge 2, sys_nRST=1 from edge 3.
//   2. btn_raw[0] 0->1 held, change just before edge 1 -> btn_level[0]=1 after edge 6;
//      btn_press[0]=1 for one cycle only. Release -> btn_release[0] pulse 6 edges later.
//   3. btn_raw[1] toggles every 2 cycles for 40 cycles, then holds at 0 ->
//      btn_level[1] stays 0; no press or release pulses.
//   4. In RUN, btn_raw[3] high 10 cycles then low ->
//      sys_nRST falls on the edge btn_level[3] rises;
//      sys_nRST stays low until 3 edges after btn_level[3] falls, then returns to 1.
//   5. sw_raw 0x0000->0xA5A5 -> sw_sync=0xA5A5 after 2 edges; sw_changed high exactly one cycle;
//      holding 0xA5A5 gives no further pulses.
//   6. Assert nRST with btn_raw[2] mid-debounce (counter=2) ->
//      outputs clear asynchronously before the next edge;
//      after release, a full 6-edge debounce is required again.

Source files
------------

// File: rtl/board_input_conditioner_if.sv
// Board-pin side of the input conditioner: raw button/switch pins in,
// conditioned levels, pulses and the stretched system reset out.
interface board_input_conditioner_if #(
    parameter int NBTN = 4,
    parameter int NSW  = 16
);
    logic [NBTN-1:0] btn_raw;
    logic [NSW-1:0]  sw_raw;
    logic [NBTN-1:0] btn_level;
    logic [NBTN-1:0] btn_press;
    logic [NBTN-1:0] btn_release;
    logic [NSW-1:0]  sw_sync;
    logic            sw_changed;
    logic            sys_nRST;

    // Board / wrapper side: drives pins, consumes conditioned signals.
    modport master (
        output btn_raw, sw_raw,
        input  btn_level, btn_press, btn_release, sw_sync, sw_changed, sys_nRST
    );

    // Conditioner side.
    modport slave (
        input  btn_raw, sw_raw,
        output btn_level, btn_press, btn_release, sw_sync, sw_changed, sys_nRST
    );
endinterface

// File: rtl/board_input_conditioner.sv
// Board input conditioner: synchronises switches, debounces buttons with
// press/release pulses, and stretches the system reset.

// Per-button debouncer working on an already synchronised input.
module board_input_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic level_nxt,
    output logic press,
    output logic rls
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          accept;

    // A change is accepted on the edge that completes DEBOUNCE_CYCLES mismatches.
    assign accept    = (din != level) && (cnt == CNT_MAX);
    assign level_nxt = accept ? din : level;

    // Count consecutive mismatches; any agreement or acceptance restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rls   <= 1'b0;
        end else begin
            level <= level_nxt;
            press <= accept & din;
            rls   <= accept & ~din;
            if (din == level || accept) cnt <= '0;
            else                        cnt <= cnt + CW'(1);
        end
    end
endmodule

module board_input_conditioner #(
    parameter int NBTN            = 4,
    parameter int NSW             = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int RST_HOLD        = 16,
    parameter int RST_BTN         = 3
) (
    input  logic                      CLK,
    input  logic                      nRST,
    board_input_conditioner_if.slave  bus
);
    localparam int NIN = NBTN + NSW;
    localparam int HW  = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HW-1:0]   HOLD_INIT = HW'(RST_HOLD - 1);
    localparam logic [NBTN-1:0] RST_SEL   = NBTN'(1) << RST_BTN;

    typedef enum logic [1:0] {HOLD, RUN, BTN} rst_state_t;

    logic [SYNC_STAGES-1:0][NIN-1:0] sync_q;
    logic [NBTN-1:0] btn_sync, btn_level, btn_level_nxt, btn_press, btn_rls;
    logic [NSW-1:0]  sw_sync, sw_prev;
    logic            sw_changed;
    logic            rst_btn;
    rst_state_t      state;
    logic [HW-1:0]   hold_cnt;
    logic            sys_q;

    // Synchroniser chains for every button and switch pin; clear to 0 so
    // reset release never produces a spurious edge.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= {bus.sw_raw, bus.btn_raw};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign btn_sync = sync_q[SYNC_STAGES-1][NBTN-1:0];
    assign sw_sync  = sync_q[SYNC_STAGES-1][NIN-1:NBTN];

    for (genvar g = 0; g < NBTN; g++) begin : g_btn
        board_input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk       (CLK),
            .rst_n     (nRST),
            .din       (btn_sync[g]),
            .level     (btn_level[g]),
            .level_nxt (btn_level_nxt[g]),
            .press     (btn_press[g]),
            .rls       (btn_rls[g])
        );
    end

    // Switch change detector; prev starts at 0 so a switch already high at
    // reset release reports one change.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sw_prev    <= '0;
            sw_changed <= 1'b0;
        end else begin
            sw_prev    <= sw_sync;
            sw_changed <= (sw_sync != sw_prev);
        end
    end

    // The FSM watches the debouncer's next level so sys_nRST drops on the
    // same edge the debounced reset button rises.
    assign rst_btn = |(btn_level_nxt & RST_SEL);

    // Reset stretcher; sys_nRST is registered from the next state.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= HOLD;
            hold_cnt <= HOLD_INIT;
            sys_q    <= 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    if (rst_btn) begin
                        state <= BTN;
                        sys_q <= 1'b0;
                    end else if (hold_cnt == '0) begin
                        state <= RUN;
                        sys_q <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - HW'(1);
                        sys_q    <= 1'b0;
                    end
                end
                RUN: begin
                    if (rst_btn) begin
                        state <= BTN;
                        sys_q <= 1'b0;
                    end else begin
                        sys_q <= 1'b1;
                    end
                end
                BTN: begin
                    sys_q <= 1'b0;
                    if (!rst_btn) begin
                        state    <= HOLD;
                        hold_cnt <= HOLD_INIT;
                    end
                end
                default: begin
                    state    <= HOLD;
                    hold_cnt <= HOLD_INIT;
                    sys_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.btn_level   = btn_level;
    assign bus.btn_press   = btn_press;
    assign bus.btn_release = btn_rls;
    assign bus.sw_sync     = sw_sync;
    assign bus.sw_changed  = sw_changed;
    assign bus.sys_nRST    = sys_q;
endmodule
